// File: rtl/point_pkg.sv
// Shared types for the dav_/rfd coordinate link: handshake FSM encoding,
// default coordinate width and the quadrant mapping used by the consumer side.
package point_pkg;

    localparam int W_DEF = 3;

    typedef enum logic [1:0] {
        S0 = 2'd0,  // idle, waiting for data and a ready consumer
        S1 = 2'd1,  // coordinates loaded, dav_ falls next edge
        S2 = 2'd2,  // waiting for the consumer to drop rfd
        S3 = 2'd3   // waiting for the consumer to become ready again
    } state_t;

    function automatic logic [1:0] quadrant(input logic [W_DEF-1:0] x,
                                            input logic [W_DEF-1:0] y);
        return {x[W_DEF-1], ~y[W_DEF-1]};
    endfunction

endpackage

// File: rtl/point_fifo.sv
// Small coordinate-pair FIFO with registered full/empty and a sticky
// overflow flag; a push is qualified against full before any same-cycle pop.
module point_fifo #(
    parameter int W     = 3,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         push_req,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic         pop,
    output logic [W-1:0] head_x,
    output logic [W-1:0] head_y,
    output logic         full,
    output logic         empty,
    output logic         overflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [2*W-1:0] mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_next;
    logic           push;
    logic           do_pop;

    assign push       = push_req && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, do_pop};
    assign {head_x, head_y} = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == FULL_COUNT);
            empty <= (count_next == '0);
            if (push_req && full)
                overflow <= 1'b1;
        end
    end

    // Storage carries no reset; the cleared pointers make stale entries unreachable.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= {in_x, in_y};
    end

endmodule

// File: rtl/point_producer.sv
// Transmit end of the dav_/rfd coordinate link: pops buffered (X,Y) pairs and
// presents each one through a four-phase handshake, counting completed transfers.
module point_producer
    import point_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int CW    = 8
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_x,
    input  logic [W-1:0]  wr_y,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          rfd,
    output logic          dav_,
    output logic [W-1:0]  X,
    output logic [W-1:0]  Y,
    output logic [CW-1:0] sent
);

    state_t       state;
    state_t       state_next;
    logic         pop;
    logic         present;
    logic         ack;
    logic [W-1:0] head_x;
    logic [W-1:0] head_y;

    point_fifo #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clock    (clock),
        .reset_   (reset_),
        .push_req (wr_en),
        .in_x     (wr_x),
        .in_y     (wr_y),
        .pop      (pop),
        .head_x   (head_x),
        .head_y   (head_y),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        present    = 1'b0;
        ack        = 1'b0;
        case (state)
            S0: begin
                if (!empty && rfd) begin
                    pop        = 1'b1;
                    state_next = S1;
                end
            end
            S1: begin
                present    = 1'b1;
                state_next = S2;
            end
            S2: begin
                if (!rfd) begin
                    ack        = 1'b1;
                    state_next = S3;
                end
            end
            S3: begin
                if (rfd)
                    state_next = S0;
            end
            default: state_next = S0;
        endcase
    end

    // X/Y load only on the pop edge, so they hold steady for the whole dav_ low window.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state <= S0;
            dav_  <= 1'b1;
            X     <= '0;
            Y     <= '0;
            sent  <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                X <= head_x;
                Y <= head_y;
            end
            if (present)
                dav_ <= 1'b0;
            if (ack) begin
                dav_ <= 1'b1;
                sent <= sent + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_point_producer.sv
// Bench for point_producer: directed scenarios plus a randomized run scored
// against a queue-based model of the FIFO and handshake.
module tb_point_producer;
    import point_pkg::*;

    localparam int W     = 3;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 8;

    logic          clock = 1'b0;
    logic          reset_;
    logic          wr_en;
    logic [W-1:0]  wr_x;
    logic [W-1:0]  wr_y;
    logic          full;
    logic          empty;
    logic          overflow;
    logic          rfd;
    logic          dav_;
    logic [W-1:0]  X;
    logic [W-1:0]  Y;
    logic [CW-1:0] sent;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    point_producer #(.W(W), .DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .rfd      (rfd),
        .dav_     (dav_),
        .X        (X),
        .Y        (Y),
        .sent     (sent)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_ = 1'b0;
        wr_en  = 1'b0;
        wr_x   = '0;
        wr_y   = '0;
        rfd    = 1'b1;
        step;
        reset_ = 1'b1;
    endtask

    // Consumer side of one handshake; ok=0 if dav_ never fell or did not rise on ack.
    task automatic recv(output logic [W-1:0] gx, output logic [W-1:0] gy, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        gx = '0;
        gy = '0;
        rfd = 1'b1;
        while (dav_ !== 1'b0 && n < 40) begin
            step;
            n++;
        end
        if (dav_ === 1'b0) begin
            gx = X;
            gy = Y;
            step;
            rfd = 1'b0;
            step;
            ok = (dav_ === 1'b1);
            rfd = 1'b1;
            step;
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({full, overflow} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags got full=%b overflow=%b exp 0 0", full, overflow);
        end
        for (int i = 0; i < 20; i++) begin
            step;
            checks++;
            if ({dav_, empty, sent, X, Y} !== {1'b1, 1'b1, 8'd0, 3'd0, 3'd0}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got dav_=%b empty=%b sent=%0d X=%0d Y=%0d exp 1 1 0 0 0",
                         i, dav_, empty, sent, X, Y);
            end
        end
    endtask

    task automatic test_single;
        rfd   = 1'b1;
        wr_x  = 3'd7;
        wr_y  = 3'd1;
        wr_en = 1'b1;
        step;
        wr_en = 1'b0;
        checks++;
        if ({empty, dav_} !== 2'b01) begin
            errors++;
            $display("FAIL single_push got empty=%b dav_=%b exp 0 1", empty, dav_);
        end
        step;
        checks++;
        if ({dav_, X, Y} !== {1'b1, 3'd7, 3'd1}) begin
            errors++;
            $display("FAIL single_load got dav_=%b X=%0d Y=%0d exp 1 7 1", dav_, X, Y);
        end
        step;
        checks++;
        if ({dav_, X, Y} !== {1'b0, 3'd7, 3'd1}) begin
            errors++;
            $display("FAIL single_present got dav_=%b X=%0d Y=%0d exp 0 7 1", dav_, X, Y);
        end
        rfd = 1'b0;
        step;
        checks++;
        if ({dav_, sent, quadrant(X, Y)} !== {1'b1, 8'd1, 2'b11}) begin
            errors++;
            $display("FAIL single_ack got dav_=%b sent=%0d q=%b exp 1 1 11", dav_, sent, quadrant(X, Y));
        end
        rfd = 1'b1;
        step;
        step;
        checks++;
        if ({dav_, empty, sent, X, Y} !== {1'b1, 1'b1, 8'd1, 3'd7, 3'd1}) begin
            errors++;
            $display("FAIL single_idle got dav_=%b empty=%b sent=%0d X=%0d Y=%0d exp 1 1 1 7 1",
                     dav_, empty, sent, X, Y);
        end
    endtask

    task automatic test_burst_overflow;
        logic [W-1:0] gx, gy;
        bit ok;
        do_reset;
        rfd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_x  = W'(i);
            wr_y  = W'(i);
            wr_en = 1'b1;
            step;
            checks++;
            if ({full, overflow} !== {(i >= 3), (i == 4)}) begin
                errors++;
                $display("FAIL burst_flags push=%0d got full=%b overflow=%b exp %b %b",
                         i, full, overflow, (i >= 3), (i == 4));
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            recv(gx, gy, ok);
            checks++;
            if (!ok || gx !== W'(i) || gy !== W'(i)) begin
                errors++;
                $display("FAIL burst_order idx=%0d got ok=%b X=%0d Y=%0d exp ok=1 X=%0d Y=%0d",
                         i, ok, gx, gy, i, i);
            end
        end
        for (int i = 0; i < 10; i++) begin
            step;
            checks++;
            if ({dav_, empty, overflow} !== 3'b111) begin
                errors++;
                $display("FAIL burst_drained cyc=%0d got dav_=%b empty=%b overflow=%b exp 1 1 1",
                         i, dav_, empty, overflow);
            end
        end
    endtask

    task automatic test_simul_push_pop;
        logic [W-1:0] ex[5];
        logic [W-1:0] ey[5];
        logic [W-1:0] gx, gy;
        bit ok;
        ex = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        ey = '{3'd6, 3'd5, 3'd4, 3'd2, 3'd1};
        do_reset;
        rfd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_x  = ex[i];
            wr_y  = ey[i];
            wr_en = 1'b1;
            step;
        end
        checks++;
        if ({full, empty} !== 2'b00) begin
            errors++;
            $display("FAIL simul_three got full=%b empty=%b exp 0 0", full, empty);
        end
        wr_x = ex[3];
        wr_y = ey[3];
        rfd  = 1'b1;
        step;
        checks++;
        if ({full, empty, X, Y} !== {1'b0, 1'b0, ex[0], ey[0]}) begin
            errors++;
            $display("FAIL simul_edge got full=%b empty=%b X=%0d Y=%0d exp 0 0 %0d %0d",
                     full, empty, X, Y, ex[0], ey[0]);
        end
        wr_x = ex[4];
        wr_y = ey[4];
        step;
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL simul_count got full=%b exp 1", full);
        end
        for (int i = 0; i < 5; i++) begin
            recv(gx, gy, ok);
            checks++;
            if (!ok || gx !== ex[i] || gy !== ey[i]) begin
                errors++;
                $display("FAIL simul_order idx=%0d got ok=%b X=%0d Y=%0d exp ok=1 X=%0d Y=%0d",
                         i, ok, gx, gy, ex[i], ey[i]);
            end
        end
        checks++;
        if ({empty, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL simul_end got empty=%b overflow=%b exp 1 0", empty, overflow);
        end
    endtask

    task automatic test_stall;
        int n;
        do_reset;
        wr_x  = 3'd5;
        wr_y  = 3'd3;
        wr_en = 1'b1;
        step;
        wr_en = 1'b0;
        n = 0;
        while (dav_ !== 1'b0 && n < 10) begin
            step;
            n++;
        end
        checks++;
        if (dav_ !== 1'b0) begin
            errors++;
            $display("FAIL stall_present got dav_=%b exp 0", dav_);
        end
        for (int i = 0; i < 10; i++) begin
            step;
            checks++;
            if ({dav_, X, Y, sent} !== {1'b0, 3'd5, 3'd3, 8'd0}) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got dav_=%b X=%0d Y=%0d sent=%0d exp 0 5 3 0",
                         i, dav_, X, Y, sent);
            end
        end
        rfd = 1'b0;
        step;
        checks++;
        if ({dav_, sent} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL stall_release got dav_=%b sent=%0d exp 1 1", dav_, sent);
        end
        rfd = 1'b1;
        step;
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset;
        wr_x  = 3'd2;
        wr_y  = 3'd7;
        wr_en = 1'b1;
        step;
        wr_x = 3'd4;
        wr_y = 3'd4;
        step;
        wr_en = 1'b0;
        n = 0;
        while (dav_ !== 1'b0 && n < 10) begin
            step;
            n++;
        end
        checks++;
        if ({dav_, empty} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_setup got dav_=%b empty=%b exp 0 0", dav_, empty);
        end
        reset_ = 1'b0;
        step;
        reset_ = 1'b1;
        checks++;
        if ({dav_, empty, full, sent, X, Y} !== {1'b1, 1'b1, 1'b0, 8'd0, 3'd0, 3'd0}) begin
            errors++;
            $display("FAIL midrst_state got dav_=%b empty=%b full=%b sent=%0d X=%0d Y=%0d exp 1 1 0 0 0 0",
                     dav_, empty, full, sent, X, Y);
        end
        for (int i = 0; i < 10; i++) begin
            step;
            checks++;
            if ({dav_, sent} !== {1'b1, 8'd0}) begin
                errors++;
                $display("FAIL midrst_quiet cyc=%0d got dav_=%b sent=%0d exp 1 0", i, dav_, sent);
            end
        end
    endtask

    // Model: accepted pairs queue in order; a dav_ fall at edge e means the
    // head was popped at edge e-1, which precedes the push decision at edge e.
    task automatic test_random;
        logic [2*W-1:0] q[$];
        logic [2*W-1:0] push_data;
        logic [2*W-1:0] head;
        logic [CW-1:0]  exp_sent;
        logic [W-1:0]   px, py;
        logic           prev_dav, push_d, rfd_d1, rfd_d2, exp_ov;
        int             cnt;
        do_reset;
        cnt      = 0;
        exp_ov   = 1'b0;
        exp_sent = '0;
        prev_dav = 1'b1;
        px       = '0;
        py       = '0;
        rfd_d1   = 1'b1;
        for (int c = 0; c < 3400; c++) begin
            wr_en = (c < 3000) && ($urandom_range(0, 2) == 0);
            wr_x  = W'($urandom);
            wr_y  = W'($urandom);
            if (dav_ === 1'b0) rfd = ($urandom_range(0, 2) != 0);
            else               rfd = ($urandom_range(0, 3) != 0);
            push_d    = wr_en;
            push_data = {wr_x, wr_y};
            rfd_d2    = rfd_d1;
            rfd_d1    = rfd;
            step;
            if (prev_dav === 1'b1 && dav_ === 1'b0) begin
                checks++;
                if (q.size() == 0 || rfd_d2 !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_fall cyc=%0d got qsize=%0d rfd_at_load=%b exp qsize>0 rfd_at_load=1",
                             c, q.size(), rfd_d2);
                end else begin
                    head = q.pop_front();
                    cnt--;
                    checks++;
                    if ({X, Y} !== head) begin
                        errors++;
                        $display("FAIL rand_data cyc=%0d got X=%0d Y=%0d exp X=%0d Y=%0d",
                                 c, X, Y, head[2*W-1:W], head[W-1:0]);
                    end
                end
            end
            if (prev_dav === 1'b0 && dav_ === 1'b1) begin
                exp_sent = exp_sent + CW'(1);
                checks++;
                if (rfd_d1 !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_rise cyc=%0d got rfd_at_rise=%b exp 0", c, rfd_d1);
                end
            end
            if (prev_dav === 1'b0 && dav_ === 1'b0) begin
                checks++;
                if ({X, Y} !== {px, py}) begin
                    errors++;
                    $display("FAIL rand_stable cyc=%0d got X=%0d Y=%0d exp X=%0d Y=%0d", c, X, Y, px, py);
                end
            end
            if (push_d) begin
                if (cnt < DEPTH) begin
                    q.push_back(push_data);
                    cnt++;
                end else begin
                    exp_ov = 1'b1;
                end
            end
            checks++;
            if ({overflow, sent} !== {exp_ov, exp_sent}) begin
                errors++;
                $display("FAIL rand_status cyc=%0d got overflow=%b sent=%0d exp overflow=%b sent=%0d",
                         c, overflow, sent, exp_ov, exp_sent);
            end
            prev_dav = dav_;
            px       = X;
            py       = Y;
        end
        checks++;
        if (q.size() != 0 || empty !== 1'b1 || dav_ !== 1'b1) begin
            errors++;
            $display("FAIL rand_drain got qsize=%0d empty=%b dav_=%b exp 0 1 1", q.size(), empty, dav_);
        end
    endtask

    initial begin
        reset_ = 1'b0;
        wr_en  = 1'b0;
        wr_x   = '0;
        wr_y   = '0;
        rfd    = 1'b1;
        test_reset;
        test_single;
        test_burst_overflow;
        test_simul_push_pop;
        test_stall;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/point_producer.md
Name: point_producer

Overview:
- Transmit end of the dav_/rfd coordinate handshake: supplies (X,Y) 3-bit coordinate pairs to a downstream quadrant consumer.
- An upstream source pushes pairs into a small internal FIFO.
- The block pops pairs one at a time and delivers each through a four-phase dav_/rfd handshake.
- Replaces the free-running bench producer with a synthesizable, back-pressured source.

Parameters:
- W, 3, coordinate width of X and Y.
- DEPTH, 4, FIFO entries; power of two.
- AW, 2, FIFO pointer width; log2(DEPTH).
- CW, 8, width of the sent-pair counter.

Ports:
- clock  in  1  single system clock; all state on posedge.
- reset_  in  1  synchronous, active-low reset, sampled on posedge clock.
- wr_en  in  1  upstream push strobe.
- wr_x  in  W  X coordinate to push.
- wr_y  in  W  Y coordinate to push.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- overflow  out  1  sticky flag: a push was attempted while full.
- rfd  in  1  consumer ready-for-data (1 = ready).
- dav_  out  1  data-available, active low.
- X  out  W  coordinate X presented to the consumer.
- Y  out  W  coordinate Y presented to the consumer.
- sent  out  CW  count of completed handshakes; wraps modulo 2^CW.

Behaviour:
- Reset (reset_==0 at posedge):
  - Outputs: dav_=1, X=0, Y=0, full=0, empty=1, overflow=0, sent=0.
  - FIFO pointers and count cleared; FSM to S0.
  - Reset mid-handshake aborts the transfer: dav_ is 1 after that edge and the in-flight pair is discarded.
- FIFO:
  - Push when wr_en=1 and full=0, evaluated before this cycle's pop.
  - wr_en=1 with full=1: data dropped, overflow set to 1 and held until reset.
  - Push and pop in the same cycle are both legal; count is unchanged.
  - full and empty are registered and derived from the post-update count.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - S0 IDLE: dav_=1. If empty=0 and rfd==1: load X,Y from the FIFO head, pop, go to S1. Otherwise stay.
  - S1 PRESENT: dav_<=0, go to S2. X,Y are stable one full cycle before dav_ falls.
  - S2 WAIT_ACK: hold dav_=0 and X,Y. When rfd==0 (consumer has latched data): dav_<=1, sent<=sent+1, go to S3.
  - S3 WAIT_RDY: dav_=1. When rfd==1, go to S0.
- Handshake invariants:
  - X and Y never change while dav_=0.
  - dav_ falls only when rfd was 1 at the load edge.
  - Exactly one pop per handshake.
- Latency: a pair pushed at edge n into an empty FIFO, with the FSM in S0 and rfd=1, is loaded at edge n+1; dav_ falls at edge n+2.
- Back-to-back throughput: at least 4 cycles per pair, plus the consumer's response time.
- sent is CW bits and wraps from 2^CW-1 to 0 silently.
- X and Y retain the last transmitted pair while idle.

Decomposition:
- Shared package (point_pkg):
  - State encodings S0=0, S1=1, S2=2, S3=3.
  - Default W=3.
  - The quadrant mapping function {x[W-1], ~y[W-1]}, used by the bench scoreboard and the consumer.
- One natural sub-module: point_fifo.
  - Parameterised by W, DEPTH, AW.
  - Stores {x,y}; provides full, empty and overflow.
  - point_producer holds only the FSM, the output registers and the counter.

Test Plan:
- Reset then idle: no pushes, rfd=1 for 20 cycles -> dav_=1, empty=1, sent=0, X=Y=0 throughout.
- Single transfer: push (X=3'b111, Y=3'b001), rfd=1 -> dav_ low at edge n+2 with X=7, Y=1. Drop rfd -> dav_ high the next edge, sent=1, and the consumer's q=2'b11.
- Burst and overflow: push 5 pairs (0,0)..(4,4) on consecutive cycles with rfd=0 -> full=1 after 4 pushes, overflow=1 on the 5th, then transmission delivers (0,0)..(3,3) in order and never (4,4).
- Simultaneous push/pop: FIFO at 3 entries, push during the S0 load edge -> count stays 3, full stays 0, ordering preserved.
- Stalled consumer: hold rfd=1 after dav_ falls for 10 cycles -> dav_ stays 0, X,Y stable, sent unchanged. Release rfd=0 -> dav_ rises the next edge.
- Reset mid-handshake: assert reset_=0 in S2 -> dav_=1, empty=1, sent=0 after that edge, and no spurious handshake follows release.
